// File: rtl/logic_gate_pipe.sv
// Registered WIDTH-bit bitwise logic unit with an output result FIFO.
// Ports: clk, rst; in_valid/in_ready, in1, in2, op; out_valid/out_ready, out, out_zero, out_ones, xfer_count.
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_zero,
  output logic             out_ones,
  output logic [15:0]      xfer_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ones;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     occ_q, occ_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] res;
  entry_t          wr_e;
  entry_t          head;
  logic            push, pop;

  // Registered occupancy only: a pop from full never frees a slot
  // in the same cycle.
  assign in_ready  = (occ_q != FULL);
  assign out_valid = (occ_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    res = '0;
    unique case (op)
      3'd0: res = in1 & in2;
      3'd1: res = in1 | in2;
      3'd2: res = in1 ^ in2;
      3'd3: res = ~(in1 & in2);
      3'd4: res = ~(in1 | in2);
      3'd5: res = ~(in1 ^ in2);
      3'd6: res = in1 & ~in2;
      3'd7: res = in1;
    endcase
  end

  always_comb begin
    wr_e      = '0;
    wr_e.res  = res;
    wr_e.zero = ~|res;
    wr_e.ones = &res;
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
      cnt_d  = cnt_q + 16'd1;
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_e;
  end

  assign head       = mem_q[rptr_q];
  assign out        = out_valid ? head.res  : '0;
  assign out_zero   = out_valid ? head.zero : 1'b1;
  assign out_ones   = out_valid ? head.ones : 1'b0;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe (WIDTH=8, DEPTH=2).
// Vector table, hand sequences and a queue-based reference model.
module tb_logic_gate_pipe;

  localparam int W = 8;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1, in2;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         out_zero, out_ones;
  logic [15:0]  xfer_count;

  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_zero(out_zero), .out_ones(out_ones),
    .xfer_count(xfer_count)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b, exp;
    logic         z, o;
  } vec_t;

  vec_t         tv [10];
  int           nvec = 0;
  int           nerr = 0;
  logic [W-1:0] mq [$];
  logic [15:0]  mcnt;
  int           mpops;

  // Per-bit truth table per op, indexed by {a,b}.
  function automatic logic [W-1:0] ref_op(
    logic [2:0] o, logic [W-1:0] a, logic [W-1:0] b);
    logic [3:0]   tt [8];
    logic [W-1:0] r;
    logic [3:0]   row;
    tt = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
           4'b0001, 4'b1001, 4'b0100, 4'b1100};
    row = tt[o];
    for (int i = 0; i < W; i++) r[i] = row[{a[i], b[i]}];
    return r;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic check_all(string n);
    chk({n, " out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({n, " in_ready"}, 32'(in_ready), 32'(mq.size() < D));
    chk({n, " xfer_count"}, 32'(xfer_count), 32'(mcnt));
    if (mq.size() != 0) begin
      chk({n, " out"}, 32'(out), 32'(mq[0]));
      chk({n, " out_zero"}, 32'(out_zero), 32'(mq[0] == '0));
      chk({n, " out_ones"}, 32'(out_ones), 32'(mq[0] == '1));
    end
  endtask

  // Advance through one rising edge, mirroring it in the model.
  task automatic tick();
    logic p, q;
    p = (mq.size() > 0) && out_ready;
    q = in_valid && (mq.size() < D);
    if (p) begin
      void'(mq.pop_front());
      mcnt++;
      mpops++;
    end
    if (q) mq.push_back(ref_op(op, in1, in2));
    @(negedge clk);
  endtask

  task automatic rnd_in();
    in1 = W'($urandom);
    in2 = W'($urandom);
    op  = 3'($urandom_range(0, 7));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    mq.delete();
    mcnt = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0] = '{3'd0, 8'hF0, 8'hCC, 8'hC0, 1'b0, 1'b0};
    tv[1] = '{3'd1, 8'hF0, 8'hCC, 8'hFC, 1'b0, 1'b0};
    tv[2] = '{3'd2, 8'hF0, 8'hCC, 8'h3C, 1'b0, 1'b0};
    tv[3] = '{3'd3, 8'hF0, 8'hCC, 8'h3F, 1'b0, 1'b0};
    tv[4] = '{3'd4, 8'hF0, 8'hCC, 8'h03, 1'b0, 1'b0};
    tv[5] = '{3'd5, 8'hF0, 8'hCC, 8'hC3, 1'b0, 1'b0};
    tv[6] = '{3'd6, 8'hF0, 8'hCC, 8'h30, 1'b0, 1'b0};
    tv[7] = '{3'd7, 8'hF0, 8'hCC, 8'hF0, 1'b0, 1'b0};
    tv[8] = '{3'd0, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0};
    tv[9] = '{3'd1, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in1 = '0; in2 = '0; op = '0;
    mcnt = '0; mpops = 0;
    #1;
    chk("rst out", 32'(out), 32'h0);
    chk("rst out_zero", 32'(out_zero), 32'h1);
    chk("rst out_ones", 32'(out_ones), 32'h0);
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all("post reset");

    // Truth table and flags, back to back.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      op = tv[i].op; in1 = tv[i].a; in2 = tv[i].b;
      tick();
      chk($sformatf("tv%0d out", i), 32'(out), 32'(tv[i].exp));
      chk($sformatf("tv%0d zero", i), 32'(out_zero), 32'(tv[i].z));
      chk($sformatf("tv%0d ones", i), 32'(out_ones), 32'(tv[i].o));
      check_all($sformatf("tv%0d", i));
    end
    in_valid = 1'b0;
    tick();
    check_all("tv drain");
    chk("tv count", 32'(xfer_count), 32'd10);

    // Backpressure with DEPTH=2.
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd7; in1 = 8'h11; in2 = 8'h5A;
    tick();
    in1 = 8'h22;
    tick();
    chk("bp full in_ready", 32'(in_ready), 32'h0);
    chk("bp head", 32'(out), 32'h11);
    in1 = 8'h33;
    tick();
    chk("bp hold head", 32'(out), 32'h11);
    check_all("bp ignored");
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp in_ready back", 32'(in_ready), 32'h1);
    chk("bp second", 32'(out), 32'h22);
    tick();
    chk("bp empty", 32'(out_valid), 32'h0);
    check_all("bp done");

    // Push/pop together at occupancy 1.
    out_ready = 1'b0;
    in_valid = 1'b1;
    rnd_in();
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rnd_in();
      tick();
      check_all($sformatf("pp%0d", i));
    end
    in_valid = 1'b0;
    tick();
    check_all("pp drain");

    // Random traffic on both sides.
    for (int i = 0; i < 200; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      rnd_in();
      tick();
      check_all($sformatf("rnd%0d", i));
    end

    // Reset with two entries queued, no clock edge needed.
    in_valid = 1'b1; out_ready = 1'b0;
    rnd_in();
    tick();
    rnd_in();
    tick();
    check_all("pre reset");
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst out_valid", 32'(out_valid), 32'h0);
    chk("mid rst in_ready", 32'(in_ready), 32'h1);
    chk("mid rst count", 32'(xfer_count), 32'h0);
    chk("mid rst out", 32'(out), 32'h0);
    chk("mid rst zero", 32'(out_zero), 32'h1);
    mq.delete();
    mcnt = '0;
    @(negedge clk);
    rst = 1'b0;
    check_all("after mid rst");

    // Counter wrap over 65537 handshakes.
    do_reset();
    mpops = 0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int g = 0; g < 70000 && mpops < 65537; g++) begin
      in1 = W'(g); in2 = W'(g >> 8); op = 3'(g);
      tick();
    end
    chk("wrap pops", 32'(mpops), 32'd65537);
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("wrap count", 32'(xfer_count), 32'h0001);
    check_all("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/logic_gate_pipe.md
# logic_gate_pipe

Parametrised, registered successor to the single-bit AND gate: a WIDTH-bit bitwise logic unit with eight selectable operations, valid/ready handshakes on both sides and a DEPTH-entry output FIFO. Results are computed on input acceptance and queued, so a stalled consumer never corrupts or drops data. The block sits between any operand producer and a result consumer in the datapath. A wrapping handshake counter supports bench and debug visibility.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and op valid
- in_ready  output  1  block can accept; high when FIFO occupancy < DEPTH
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- op  input  3  operation select, sampled with in1/in2
- out_valid  output  1  FIFO head holds a result
- out_ready  input  1  consumer accepts head
- out  output  WIDTH  result at FIFO head
- out_zero  output  1  head result is all zeros
- out_ones  output  1  head result is all ones
- xfer_count  output  16  number of completed output handshakes, wrapping

## Operation
- Input handshake: in_valid & in_ready on a rising edge → result computed from in1, in2, op and written to FIFO tail.
- op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (in1 & ~in2), 7 PASS (in1). All eight codes valid; no error path.
- out_zero/out_ones computed at write time and stored with the result; for WIDTH=1 exactly one of them is high whenever out_valid=1.
- Output handshake: out_valid & out_ready → head popped, xfer_count += 1; 0xFFFF wraps to 0x0000.
- FIFO: circular buffer, read/write pointers of log2(DEPTH) bits wrapping naturally; occupancy counter 0..DEPTH.
- in_ready depends only on registered occupancy (no combinational path from out_ready). When full, a same-cycle pop does not enable a push.
- Simultaneous push and pop (occupancy 1..DEPTH-1): occupancy unchanged, both pointers advance.
- out, out_zero, out_ones are don't-care when out_valid=0, but must be driven (no X) after reset.
- Inputs while in_ready=0 are ignored; producer must hold them.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): in_ready=1 after reset, out_valid=0, out=0, out_zero=1, out_ones=0, xfer_count=0, pointers and occupancy 0. Reset mid-transfer discards all queued results immediately.
- Latency: accept at edge N → out_valid=1 and correct out from edge N (visible in cycle N+1) when FIFO was empty.
- Throughput: one result per cycle sustained with out_ready held high.
- in_ready deasserts the cycle after occupancy reaches DEPTH; reasserts the cycle after a pop from full.
- out_valid stays high and out stays stable while out_ready=0.
- xfer_count updates on the edge of the output handshake.

## Test plan
- Reset: assert rst mid-run with 2 entries queued → out_valid=0, in_ready=1, xfer_count=0, out=0 immediately, no clock required.
- Truth table, WIDTH=8: in1=0xF0, in2=0xCC, op 0..7 back-to-back, out_ready=1 → out = 0xC0, 0xFC, 0x3C, 0x3F, 0x03, 0xC3, 0x30, 0xF0, one per cycle, each one cycle after acceptance.
- Flags: op=0, in1=0x0F, in2=0xF0 → out=0x00, out_zero=1; op=1 same operands → out=0xFF, out_ones=1, out_zero=0.
- Backpressure, DEPTH=2: out_ready=0, push 0x11, 0x22 (op=7) → in_ready=0 after second accept, third push ignored; raise out_ready → 0x11 then 0x22 in order, in_ready returns high one cycle after first pop.
- Simultaneous push/pop with occupancy 1 over 20 cycles, random operands → no loss, no duplication, order preserved, scoreboard match.
- Counter wrap: force 65 537 output handshakes → xfer_count reads 0x0001.
